// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter and byte/half/word sequencer
// for a word-wide data memory. Build option: DMEM_BOUNDS_CHECK_EN.
module dmem_arbiter #(
    parameter int unsigned DEPTH      = 11,
    parameter bit          RESET_LAST = 1'b1
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [3:0]  size,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic [1:0]  gnt,
    output logic [1:0]  rvalid,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WB,
        RESP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic        last_q;
    logic        id_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] merge_q;

    logic        pick_id;
    logic        grant;
    logic        sel_we;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_legal;
    logic        in_range;

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [31:0] lane_mask;
    logic [31:0] merged;

    // Pick the winner: a lone request wins, a tie goes to the other side.
    always_comb begin
        pick_id = 1'b0;
        if (req == 2'b11) begin
            pick_id = ~last_q;
        end else if (req[1]) begin
            pick_id = 1'b1;
        end
    end

    assign grant = rst_n && (state_q == IDLE) && (|req);
    assign gnt   = grant ? (pick_id ? 2'b10 : 2'b01) : 2'b00;

    // Route the winning requester's fields toward the capture registers.
    always_comb begin
        sel_we    = pick_id ? we[1] : we[0];
        sel_size  = pick_id ? size[3:2] : size[1:0];
        sel_addr  = pick_id ? addr[63:32] : addr[31:0];
        sel_wdata = pick_id ? wdata[63:32] : wdata[31:0];
    end

`ifdef DMEM_BOUNDS_CHECK_EN
    assign in_range = ({2'b00, sel_addr[31:2]} < 32'(DEPTH));
`else
    // DEPTH only matters when range checking is compiled in.
    logic [31:0] depth_unused;
    assign depth_unused = 32'(DEPTH);
    assign in_range     = 1'b1;
`endif

    // Size/alignment legality of the winning request.
    always_comb begin
        sel_legal = 1'b0;
        unique case (sel_size)
            2'b00:   sel_legal = 1'b1;
            2'b01:   sel_legal = ~sel_addr[0];
            2'b10:   sel_legal = (sel_addr[1:0] == 2'b00);
            default: sel_legal = 1'b0;
        endcase
        sel_legal = sel_legal & in_range;
    end

    // Lane extraction for loads and lane merge for sub-word stores.
    always_comb begin
        shamt     = {addr_q[1:0], 3'b000};
        shifted   = mem_rd >> shamt;
        load_data = mem_rd;
        lane_mask = 32'hFFFF_FFFF;
        unique case (size_q)
            2'b00: begin
                load_data = {24'h0, shifted[7:0]};
                lane_mask = 32'h0000_00FF << shamt;
            end
            2'b01: begin
                load_data = {16'h0, shifted[15:0]};
                lane_mask = 32'h0000_FFFF << shamt;
            end
            default: begin
                load_data = mem_rd;
                lane_mask = 32'hFFFF_FFFF;
            end
        endcase
        merged = (mem_rd & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
    end

    // State register.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the granted request and the EXEC-cycle memory data.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= RESET_LAST;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            merge_q <= 32'h0;
        end else begin
            if (grant) begin
                last_q  <= pick_id;
                id_q    <= pick_id;
                we_q    <= sel_we;
                size_q  <= sel_size;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                err_q   <= ~sel_legal;
                rdata_q <= 32'h0;
            end
            if (state_q == EXEC) begin
                if (!we_q) begin
                    rdata_q <= load_data;
                end else begin
                    merge_q <= merged;
                end
            end
        end
    end

    // Next state and memory/response outputs.
    always_comb begin
        state_d = state_q;
        mem_we  = 1'b0;
        mem_a   = 32'h0;
        mem_wd  = 32'h0;
        rvalid  = 2'b00;
        rdata   = 32'h0;
        err     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = sel_legal ? EXEC : RESP;
                end
            end
            EXEC: begin
                mem_a = {addr_q[31:2], 2'b00};
                if (we_q && (size_q == 2'b10)) begin
                    mem_we  = 1'b1;
                    mem_wd  = wdata_q;
                    state_d = RESP;
                end else if (we_q) begin
                    state_d = WB;
                end else begin
                    state_d = RESP;
                end
            end
            WB: begin
                mem_a   = {addr_q[31:2], 2'b00};
                mem_we  = 1'b1;
                mem_wd  = merge_q;
                state_d = RESP;
            end
            RESP: begin
                rvalid  = id_q ? 2'b10 : 2'b01;
                err     = err_q;
                rdata   = rdata_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter
// with a small word memory model on the memory port.
module tb_dmem_arbiter;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [3:0]  size;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] tmem [0:15];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    dmem_arbiter #(
        .DEPTH(11),
        .RESET_LAST(1'b1)
    ) dut (
        .CLK(CLK),
        .rst_n(rst_n),
        .req(req),
        .we(we),
        .size(size),
        .addr(addr),
        .wdata(wdata),
        .gnt(gnt),
        .rvalid(rvalid),
        .rdata(rdata),
        .err(err),
        .mem_we(mem_we),
        .mem_a(mem_a),
        .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    assign mem_rd = (mem_a[31:6] == 26'h0 && mem_a[1:0] == 2'b00)
                    ? tmem[mem_a[5:2]] : 32'hBAD0_BAD0;

    always @(posedge CLK) begin
        if (mem_we) tmem[mem_a[5:2]] <= mem_wd;
    end

    task automatic drive(input bit id, input logic w,
                         input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] d);
        @(negedge CLK);
        if (id) begin
            we[1] = w; size[3:2] = s; addr[63:32] = a; wdata[63:32] = d;
            req[1] = 1'b1;
        end else begin
            we[0] = w; size[1:0] = s; addr[31:0] = a; wdata[31:0] = d;
            req[0] = 1'b1;
        end
        #1;
    endtask

    task automatic drop();
        @(posedge CLK);
        #1 req = 2'b00;
        @(negedge CLK);
        #1;
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 2'b11; we = 2'b00; size = 4'b1010;
        addr = 64'h0; wdata = 64'h0;
        repeat (2) step();
        n_tests++;
        if (gnt !== 2'b00) begin
            n_fail++; $display("FAIL rst_gnt: got %b want 00", gnt);
        end
        n_tests++;
        if (rvalid !== 2'b00 || err !== 1'b0 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_resp: rvalid %b err %b rdata %h want 0",
                     rvalid, err, rdata);
        end
        n_tests++;
        if (mem_we !== 1'b0 || mem_a !== 32'h0 || mem_wd !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mem: we %b a %h wd %h want 0",
                     mem_we, mem_a, mem_wd);
        end
        req = 2'b00;
        @(negedge CLK);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_word_store_load();
        drive(0, 1'b1, 2'b10, 32'h8, 32'hDEADBEEF);
        n_tests++;
        if (gnt !== 2'b01 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL wst_gnt: gnt %b we %b want 01 0", gnt, mem_we);
        end
        drop();
        n_tests++;
        if (mem_we !== 1'b1 || mem_a !== 32'h8 || mem_wd !== 32'hDEADBEEF
            || rvalid !== 2'b00) begin
            n_fail++;
            $display("FAIL wst_exec: we %b a %h wd %h rv %b want 1 8 deadbeef 00",
                     mem_we, mem_a, mem_wd, rvalid);
        end
        step();
        n_tests++;
        if (rvalid !== 2'b01 || err !== 1'b0 || rdata !== 32'h0
            || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL wst_resp: rv %b err %b rdata %h we %b want 01 0 0 0",
                     rvalid, err, rdata, mem_we);
        end
        drive(0, 1'b0, 2'b10, 32'h8, 32'h0);
        n_tests++;
        if (gnt !== 2'b01) begin
            n_fail++; $display("FAIL wld_gnt: got %b want 01", gnt);
        end
        drop();
        n_tests++;
        if (mem_we !== 1'b0 || mem_a !== 32'h8 || rvalid !== 2'b00) begin
            n_fail++;
            $display("FAIL wld_exec: we %b a %h rv %b want 0 8 00",
                     mem_we, mem_a, rvalid);
        end
        step();
        n_tests++;
        if (rvalid !== 2'b01 || rdata !== 32'hDEADBEEF || err !== 1'b0) begin
            n_fail++;
            $display("FAIL wld_resp: rv %b rdata %h err %b want 01 deadbeef 0",
                     rvalid, rdata, err);
        end
    endtask

    task automatic test_byte_rmw();
        drive(1, 1'b1, 2'b00, 32'hA, 32'h55);
        n_tests++;
        if (gnt !== 2'b10) begin
            n_fail++; $display("FAIL bst_gnt: got %b want 10", gnt);
        end
        drop();
        n_tests++;
        if (mem_we !== 1'b0 || mem_a !== 32'h8 || rvalid !== 2'b00) begin
            n_fail++;
            $display("FAIL bst_exec: we %b a %h rv %b want 0 8 00",
                     mem_we, mem_a, rvalid);
        end
        step();
        n_tests++;
        if (mem_we !== 1'b1 || mem_a !== 32'h8 || mem_wd !== 32'hDE55BEEF
            || rvalid !== 2'b00) begin
            n_fail++;
            $display("FAIL bst_wb: we %b a %h wd %h rv %b want 1 8 de55beef 00",
                     mem_we, mem_a, mem_wd, rvalid);
        end
        step();
        n_tests++;
        if (rvalid !== 2'b10 || err !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL bst_resp: rv %b err %b we %b want 10 0 0",
                     rvalid, err, mem_we);
        end
        drive(1, 1'b0, 2'b01, 32'hA, 32'h0);
        drop();
        step();
        n_tests++;
        if (rvalid !== 2'b10 || rdata !== 32'h0000DE55) begin
            n_fail++;
            $display("FAIL hld: rv %b rdata %h want 10 0000de55", rvalid, rdata);
        end
        drive(0, 1'b0, 2'b00, 32'hB, 32'h0);
        drop();
        step();
        n_tests++;
        if (rvalid !== 2'b01 || rdata !== 32'h000000DE) begin
            n_fail++;
            $display("FAIL bld: rv %b rdata %h want 01 000000de", rvalid, rdata);
        end
        drive(0, 1'b1, 2'b01, 32'h8, 32'h1234);
        drop();
        step();
        n_tests++;
        if (mem_we !== 1'b1 || mem_wd !== 32'hDE551234) begin
            n_fail++;
            $display("FAIL hst_wb: we %b wd %h want 1 de551234", mem_we, mem_wd);
        end
        step();
    endtask

    task automatic test_misaligned();
        drive(0, 1'b0, 2'b10, 32'h6, 32'h0);
        n_tests++;
        if (gnt !== 2'b01 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL mis_gnt: gnt %b we %b want 01 0", gnt, mem_we);
        end
        drop();
        n_tests++;
        if (rvalid !== 2'b01 || err !== 1'b1 || rdata !== 32'h0
            || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_word: rv %b err %b rdata %h we %b want 01 1 0 0",
                     rvalid, err, rdata, mem_we);
        end
        drive(1, 1'b1, 2'b11, 32'h8, 32'hFFFFFFFF);
        n_tests++;
        if (gnt !== 2'b10 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL sz3_gnt: gnt %b we %b want 10 0", gnt, mem_we);
        end
        drop();
        n_tests++;
        if (rvalid !== 2'b10 || err !== 1'b1 || rdata !== 32'h0
            || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL sz3: rv %b err %b rdata %h we %b want 10 1 0 0",
                     rvalid, err, rdata, mem_we);
        end
        drive(0, 1'b1, 2'b01, 32'h9, 32'hFFFF);
        drop();
        n_tests++;
        if (rvalid !== 2'b01 || err !== 1'b1 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_half: rv %b err %b we %b want 01 1 0",
                     rvalid, err, mem_we);
        end
        drive(0, 1'b0, 2'b10, 32'h8, 32'h0);
        drop();
        step();
        n_tests++;
        if (rvalid !== 2'b01 || err !== 1'b0 || rdata !== 32'hDE551234) begin
            n_fail++;
            $display("FAIL mis_keep: rv %b err %b rdata %h want 01 0 de551234",
                     rvalid, err, rdata);
        end
    endtask

    task automatic test_reset_in_wb();
        drive(0, 1'b1, 2'b10, 32'h10, 32'h11223344);
        drop();
        step();
        drive(0, 1'b1, 2'b00, 32'h11, 32'hAA);
        drop();
        step();
        n_tests++;
        if (mem_we !== 1'b1 || mem_wd !== 32'h1122AA44) begin
            n_fail++;
            $display("FAIL wb_pre: we %b wd %h want 1 1122aa44", mem_we, mem_wd);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (mem_we !== 1'b0 || rvalid !== 2'b00 || gnt !== 2'b00) begin
            n_fail++;
            $display("FAIL wb_rst: we %b rv %b gnt %b want 0 00 00",
                     mem_we, rvalid, gnt);
        end
        @(negedge CLK);
        rst_n = 1'b1;
        #1;
        step();
        n_tests++;
        if (rvalid !== 2'b00 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL wb_norsp: rv %b we %b want 00 0", rvalid, mem_we);
        end
        drive(1, 1'b0, 2'b10, 32'h10, 32'h0);
        drop();
        step();
        n_tests++;
        if (rvalid !== 2'b10 || rdata !== 32'h11223344) begin
            n_fail++;
            $display("FAIL wb_keep: rv %b rdata %h want 10 11223344", rvalid, rdata);
        end
    endtask

    task automatic test_contention();
        @(negedge CLK);
        rst_n = 1'b0;
        we = 2'b00; size = 4'b1010;
        addr = {32'h10, 32'h8}; wdata = 64'h0;
        req = 2'b11;
        @(negedge CLK);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (gnt !== 2'b01) begin
            n_fail++; $display("FAIL arb_g1: got %b want 01", gnt);
        end
        step();
        n_tests++;
        if (gnt !== 2'b00 || rvalid !== 2'b00) begin
            n_fail++; $display("FAIL arb_busy: gnt %b rv %b want 00 00", gnt, rvalid);
        end
        step();
        n_tests++;
        if (rvalid !== 2'b01 || rdata !== 32'hDE551234 || gnt !== 2'b00) begin
            n_fail++;
            $display("FAIL arb_r1: rv %b rdata %h gnt %b want 01 de551234 00",
                     rvalid, rdata, gnt);
        end
        step();
        n_tests++;
        if (gnt !== 2'b10) begin
            n_fail++; $display("FAIL arb_g2: got %b want 10", gnt);
        end
        step();
        step();
        n_tests++;
        if (rvalid !== 2'b10 || rdata !== 32'h11223344) begin
            n_fail++;
            $display("FAIL arb_r2: rv %b rdata %h want 10 11223344", rvalid, rdata);
        end
        step();
        n_tests++;
        if (gnt !== 2'b01) begin
            n_fail++; $display("FAIL arb_g3: got %b want 01", gnt);
        end
        drop();
        step();
        drive(1, 1'b0, 2'b10, 32'h8, 32'h0);
        n_tests++;
        if (gnt !== 2'b10) begin
            n_fail++; $display("FAIL solo_a: got %b want 10", gnt);
        end
        drop();
        step();
        drive(1, 1'b0, 2'b10, 32'h8, 32'h0);
        n_tests++;
        if (gnt !== 2'b10) begin
            n_fail++; $display("FAIL solo_b: got %b want 10", gnt);
        end
        drop();
        step();
        n_tests++;
        if (rvalid !== 2'b10 || rdata !== 32'hDE551234) begin
            n_fail++;
            $display("FAIL solo_r: rv %b rdata %h want 10 de551234", rvalid, rdata);
        end
    endtask

    task automatic test_bounds();
`ifdef DMEM_BOUNDS_CHECK_EN
        drive(0, 1'b1, 2'b10, 32'h2C, 32'hCAFEF00D);
        drop();
        n_tests++;
        if (rvalid !== 2'b01 || err !== 1'b1 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL oob: rv %b err %b we %b want 01 1 0", rvalid, err, mem_we);
        end
        drive(0, 1'b1, 2'b10, 32'h28, 32'hCAFEF00D);
        drop();
        n_tests++;
        if (mem_we !== 1'b1 || mem_a !== 32'h28) begin
            n_fail++;
            $display("FAIL inb_exec: we %b a %h want 1 28", mem_we, mem_a);
        end
        step();
        n_tests++;
        if (rvalid !== 2'b01 || err !== 1'b0) begin
            n_fail++; $display("FAIL inb_resp: rv %b err %b want 01 0", rvalid, err);
        end
`else
        drive(0, 1'b1, 2'b10, 32'h2C, 32'hCAFEF00D);
        drop();
        n_tests++;
        if (mem_we !== 1'b1 || mem_a !== 32'h2C) begin
            n_fail++;
            $display("FAIL nochk_exec: we %b a %h want 1 2c", mem_we, mem_a);
        end
        step();
        n_tests++;
        if (rvalid !== 2'b01 || err !== 1'b0) begin
            n_fail++; $display("FAIL nochk_resp: rv %b err %b want 01 0", rvalid, err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_word_store_load();
        test_byte_rmw();
        test_misaligned();
        test_reset_in_wb();
        test_contention();
        test_bounds();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and access sequencer in front of the word-addressable data memory.
- Requester 0 is the core load/store unit; requester 1 is the debug/program-loader port.
- Shares the single memory port using round-robin arbitration.
- Supports byte, halfword and word accesses; sub-word stores are done as read-modify-write, since the memory writes whole words only.

Parameters:
- DEPTH, 11: number of 32-bit words in the attached memory.
- RESET_LAST, 1: value loaded into the last-grant register at reset, so requester 0 wins the first contention.

Ports:
- CLK  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  2  request per requester; bit n is requester n.
- we  input  2  per-requester store (1) or load (0).
- size  input  4  2 bits per requester, size[2n+1:2n]: 00 byte, 01 half, 10 word, 11 illegal.
- addr  input  64  32-bit byte address per requester, addr[32n+31:32n].
- wdata  input  64  32-bit store data per requester; sub-word data is right-justified.
- gnt  output  2  one-hot acceptance pulse.
- rvalid  output  2  one-hot completion pulse.
- rdata  output  32  load data, zero-extended; shared by both requesters.
- err  output  1  valid with rvalid; access rejected.
- mem_we  output  1  memory write enable.
- mem_a  output  32  memory byte address, always word-aligned.
- mem_wd  output  32  memory write data.
- mem_rd  input  32  memory read data, combinational from mem_a.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, last-grant = RESET_LAST.
  - gnt, rvalid, rdata, err, mem_we, mem_a, mem_wd all 0.
  - gnt is forced to 0 while rst_n is low.
- States: IDLE, EXEC, WB, RESP.
- IDLE:
  - If exactly one req bit is set, grant that requester.
  - If both are set, grant the requester that is not last-grant.
  - gnt is combinational in IDLE, asserted for exactly one cycle.
  - At that edge: latch we/size/addr/wdata/id, update last-grant.
  - Next state: EXEC if legal, else RESP with err pending.
- Requester handshake: hold req and all fields stable until gnt is seen; deassert at or after that edge. A req still high in RESP is a new request.
- Legality:
  - size 11 is illegal.
  - Half requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - Illegal requests never touch memory (mem_we stays 0).
- EXEC:
  - mem_a = {addr[31:2],2'b00}.
  - Load: capture the selected lane of mem_rd, little-endian. Byte lane = addr[1:0]; half lane = addr[1]. Zero-extend into rdata. Go to RESP.
  - Word store: mem_we=1, mem_wd=wdata. Go to RESP.
  - Sub-word store: mem_we=0; merge the wdata lane into the captured mem_rd word. Go to WB.
- WB: mem_we=1, mem_a unchanged, mem_wd = merged word. Go to RESP.
- RESP:
  - rvalid[id]=1 for one cycle, with err and rdata valid.
  - rdata=0 for stores and errors.
  - Next state: IDLE.
- mem_we is asserted only in EXEC (word store) or WB; never in IDLE/RESP.
- Latency from gnt cycle T:
  - Loads and word stores: rvalid at T+2.
  - Sub-word stores: rvalid at T+3.
  - Illegal requests: rvalid at T+1.
- Throughput: at most one grant per 2 cycles, since no grant is issued in EXEC/WB/RESP.
- Reset mid-operation:
  - Transaction is abandoned with no rvalid.
  - mem_we drops immediately, so an RMW reset in WB before the edge leaves memory unmodified.
  - The requester must reissue.
- Simultaneous req on both while busy: nothing is granted until IDLE; the pending pair is then arbitrated by last-grant.

Optional Feature:
- Macro: DMEM_BOUNDS_CHECK_EN.
- Defined:
  - A legal request with addr[31:2] >= DEPTH is treated as illegal (err=1, no memory access, rvalid at T+1).
  - Extra states or ports: none.
- Undefined:
  - No range check; mem_a is passed through unmodified.
  - Out-of-range behaviour is whatever the memory does.

Test Plan:
- Word store then load:
  - r0 stores 0xDEADBEEF at addr 0x8 → mem_we high one cycle at T+1, mem_a=0x8, rvalid[0] at T+2, err=0.
  - r0 load of 0x8 → rdata=0xDEADBEEF.
- Byte RMW:
  - Memory word 0x8 = 0xDEADBEEF; r1 byte store 0x55 at addr 0xA.
  - mem_we=0 at T+1, mem_we=1 at T+2 with mem_wd=0xDE55BEEF, rvalid[1] at T+3.
  - Half load at 0xA → rdata=0x0000DE55.
- Contention:
  - req=11 held from reset → gnt sequence 01,10,01; each grant follows the previous RESP.
  - r1 alone → granted immediately.
- Misaligned:
  - Word load at 0x6 → rvalid at T+1, err=1, rdata=0, mem_we never high.
  - Size 11 store → same response.
- Reset in WB:
  - Assert rst_n low during WB of a byte store → mem_we drops same cycle, no rvalid.
  - Word unchanged on readback after reset.
- Bounds (macro defined, DEPTH=11):
  - Word store at 0x2C → err=1, no mem_we.
  - Same store at 0x28 succeeds.
